// File: rtl/hilo_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mdu_pkg
// Description : Shared MDU op codes, FSM state encodings and op-class helpers
//               used by the HI/LO multiply/divide unit and the ID/EX latch.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_mdu_pkg;

    // MDU op codes, shared with the ID/EX latch
    localparam logic [2:0] c_OP_NONE  = 3'd0;
    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    // Controller state encodings
    localparam int         c_STATE_W     = 2;
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_MUL      = 2'd1;
    localparam logic [1:0] c_ST_DIV      = 2'd2;
    localparam logic [1:0] c_ST_DIV_FIX  = 2'd3;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == c_OP_MULT) || (op == c_OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == c_OP_DIV) || (op == c_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_mdu_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : One unsigned restoring radix-2 divide step. Shifts the next
//               dividend bit (MSB of the quotient register) into the partial
//               remainder, trial-subtracts the divisor and shifts the quotient
//               bit into the LSB of the quotient register.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    // Extra top bit so the trial subtraction's borrow is visible
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    // Keep the difference when no borrow occurred, otherwise restore
    always_comb begin
        if (!w_diff[WIDTH]) begin
            o_rem = w_diff[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shift[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_mdu.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mdu
// Description : EX-stage multiply/divide unit owning HI/LO. Multi-cycle
//               MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO, flushable by
//               cancel. HI/LO change only at a result edge.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int MULT_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int c_CNT_MAX = (WIDTH > MULT_LATENCY) ? WIDTH - 1 : MULT_LATENCY - 1;
    localparam int c_CNT_W   = (c_CNT_MAX < 1) ? 1 : $clog2(c_CNT_MAX + 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    // r_a: multiplicand, or dividend/quotient shift register
    // r_b: multiplier, or divisor magnitude
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_rs_orig;
    logic                 r_mul_signed;
    logic                 r_neg_q;
    logic                 r_neg_r;

    logic w_accept_mul;
    logic w_accept_div;
    logic w_mul_fin;
    logic w_div_fin;
    logic w_wr_hi;
    logic w_wr_lo;

    // Operand conditioning for signed divide: magnitudes plus recorded signs
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_abs;
    logic [WIDTH-1:0] w_rt_abs;

    assign w_rs_neg = (op == c_OP_DIV) && rs_data[WIDTH-1];
    assign w_rt_neg = (op == c_OP_DIV) && rt_data[WIDTH-1];
    assign w_rs_abs = w_rs_neg ? (~rs_data + 1'b1) : rs_data;
    assign w_rt_abs = w_rt_neg ? (~rt_data + 1'b1) : rt_data;

    // Single multiplier: sign- or zero-extend to 2*WIDTH, low half of the
    // extended product is the exact signed/unsigned full product
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_product;

    assign w_a_ext   = {{WIDTH{r_mul_signed & r_a[WIDTH-1]}}, r_a};
    assign w_b_ext   = {{WIDTH{r_mul_signed & r_b[WIDTH-1]}}, r_b};
    assign w_product = w_a_ext * w_b_ext;

    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    div_iter #(
        .WIDTH     (WIDTH)
    ) u_div_iter (
        .i_rem     (r_rem),
        .i_quo     (r_a),
        .i_divisor (r_b),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    // Sign fix-up and divide-by-zero override applied at the final edge
    logic             w_div_by_zero;
    logic [WIDTH-1:0] w_quo_final;
    logic [WIDTH-1:0] w_rem_final;

    assign w_div_by_zero = (r_b == '0);
    assign w_quo_final   = w_div_by_zero ? '1        : (r_neg_q ? (~r_a + 1'b1)   : r_a);
    assign w_rem_final   = w_div_by_zero ? r_rs_orig : (r_neg_r ? (~r_rem + 1'b1) : r_rem);

    // Next-state and per-edge action decode; cancel outranks start and completion
    always_comb begin
        w_state_next = r_state;
        w_accept_mul = 1'b0;
        w_accept_div = 1'b0;
        w_mul_fin    = 1'b0;
        w_div_fin    = 1'b0;
        w_wr_hi      = 1'b0;
        w_wr_lo      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start && !cancel) begin
                    if (is_mul_op(op)) begin
                        w_accept_mul = 1'b1;
                        w_state_next = c_ST_MUL;
                    end else if (is_div_op(op)) begin
                        w_accept_div = 1'b1;
                        w_state_next = c_ST_DIV;
                    end else if (op == c_OP_MTHI) begin
                        w_wr_hi = 1'b1;
                    end else if (op == c_OP_MTLO) begin
                        w_wr_lo = 1'b1;
                    end
                end
            end
            c_ST_MUL: begin
                if (cancel) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_mul_fin    = 1'b1;
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_DIV: begin
                if (cancel) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = c_ST_DIV_FIX;
                end
            end
            c_ST_DIV_FIX: begin
                w_state_next = c_ST_IDLE;
                w_div_fin    = !cancel;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: operand latches, divider iteration, counter, HI/LO and done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_done       <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_rem        <= '0;
            r_rs_orig    <= '0;
            r_mul_signed <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
        end else begin
            r_done <= w_mul_fin | w_div_fin;
            if (w_wr_hi) r_hi <= rs_data;
            if (w_wr_lo) r_lo <= rs_data;
            if (w_accept_mul) begin
                r_a          <= rs_data;
                r_b          <= rt_data;
                r_mul_signed <= (op == c_OP_MULT);
                r_cnt        <= c_CNT_W'(MULT_LATENCY - 1);
            end
            if (w_accept_div) begin
                r_a       <= w_rs_abs;
                r_b       <= w_rt_abs;
                r_rem     <= '0;
                r_rs_orig <= rs_data;
                r_neg_q   <= w_rs_neg ^ w_rt_neg;
                r_neg_r   <= w_rs_neg;
                r_cnt     <= c_CNT_W'(WIDTH - 1);
            end
            if (r_state == c_ST_MUL && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == c_ST_DIV && !cancel) begin
                r_rem <= w_rem_next;
                r_a   <= w_quo_next;
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            if (w_mul_fin) begin
                r_hi <= w_product[2*WIDTH-1:WIDTH];
                r_lo <= w_product[WIDTH-1:0];
            end
            if (w_div_fin) begin
                r_hi <= w_rem_final;
                r_lo <= w_quo_final;
            end
        end
    end

    assign busy   = (r_state != c_ST_IDLE);
    assign done   = r_done;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

    // Protocol check: the hazard unit must not issue while an op is in flight
    a_no_start_while_busy: assert property (@(posedge clk) disable iff (rst) !(start && busy));

endmodule
`default_nettype wire
